// File: rtl/epmp_mem_seq.sv
// epmp_mem_seq: arbitrates a fetch unit and a data unit onto one memory port.
// Each access goes through IDLE -> LOAD -> ACCESS -> DONE.
// In LOAD the winner's address is driven to the MAR buses (IBH/IBL) and loaded.
// In ACCESS the block strobes mem_rd or mem_wr until mem_rdy or a timeout.
// In DONE it pulses done to the owner, with err set if the access timed out.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   if_req/if_addr          fetch requester (always a read)
//   du_req/du_we/du_addr/du_wdata  data requester
//   if_gnt/du_gnt           grant pulse (LOAD)
//   if_done/du_done/err     completion pulse (DONE), err = timeout
//   rdata                   last successful read data
//   IBL/IBH/MAR_Load        MAR address buses and load strobe
//   mem_rd/mem_wr/mem_wdata/mem_rdata/mem_rdy  memory handshake
module epmp_mem_seq #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        du_req,
   input  logic        du_we,
   input  logic [15:0] du_addr,
   input  logic [7:0]  du_wdata,
   output logic        if_gnt,
   output logic        du_gnt,
   output logic        if_done,
   output logic        du_done,
   output logic        err,
   output logic [7:0]  rdata,
   output logic [7:0]  IBL,
   output logic [7:0]  IBH,
   output logic        MAR_Load,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_rdy
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACCESS, S_DONE} state_t;

   // Value of the wait counter on the last ACCESS cycle allowed.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [7:0]  wdata_q, wdata_d;
   // Last grant doubles as the owner of the current access (1 = data unit).
   logic        own_du_q, own_du_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        pick_du;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         own_du_q <= 1'b1;   // fetch unit wins the first tie
         cnt_q    <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         own_du_q <= own_du_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      own_du_d = own_du_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      // Data unit wins alone, or on a tie when the fetch unit was granted last.
      pick_du  = du_req & (~if_req | ~own_du_q);
      unique case (state_q)
         S_IDLE: begin
            if (if_req || du_req) begin
               state_d  = S_LOAD;
               own_du_d = pick_du;
               addr_d   = pick_du ? du_addr : if_addr;
               we_d     = pick_du & du_we;
               wdata_d  = pick_du ? du_wdata : 8'h00;
            end
         end
         S_LOAD: begin
            state_d = S_ACCESS;
            cnt_d   = '0;
            err_d   = 1'b0;
         end
         S_ACCESS: begin
            cnt_d = cnt_q + 8'd1;
            // mem_rdy wins over a timeout landing on the same edge.
            if (mem_rdy) begin
               state_d = S_DONE;
               err_d   = 1'b0;
               if (!we_q) rdata_d = mem_rdata;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from state and registered data only.
   assign MAR_Load  = (state_q == S_LOAD);
   assign IBH       = MAR_Load ? addr_q[15:8] : 8'h00;
   assign IBL       = MAR_Load ? addr_q[7:0]  : 8'h00;
   assign if_gnt    = MAR_Load & ~own_du_q;
   assign du_gnt    = MAR_Load & own_du_q;
   assign mem_rd    = (state_q == S_ACCESS) & ~we_q;
   assign mem_wr    = (state_q == S_ACCESS) & we_q;
   assign mem_wdata = mem_wr ? wdata_q : 8'h00;
   assign if_done   = (state_q == S_DONE) & ~own_du_q;
   assign du_done   = (state_q == S_DONE) & own_du_q;
   assign err       = (state_q == S_DONE) & err_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_epmp_mem_seq.sv
// Bench for epmp_mem_seq: table of transactions with expected results,
// a scoreboard queue whose head also drives the memory model, and
// hand-written tie and reset-mid-access sequences.
module tb_epmp_mem_seq;
   localparam int TO = 15;

   logic clk = 1'b0, rst_n = 1'b0;
   logic if_req = 1'b0, du_req = 1'b0, du_we = 1'b0;
   logic [15:0] if_addr = '0, du_addr = '0;
   logic [7:0] du_wdata = '0, mem_rdata = '0;
   logic mem_rdy = 1'b0;
   logic if_gnt, du_gnt, if_done, du_done, err, MAR_Load, mem_rd, mem_wr;
   logic [7:0] rdata, IBL, IBH, mem_wdata;

   epmp_mem_seq #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
      .du_req(du_req), .du_we(du_we), .du_addr(du_addr), .du_wdata(du_wdata),
      .if_gnt(if_gnt), .du_gnt(du_gnt), .if_done(if_done), .du_done(du_done),
      .err(err), .rdata(rdata), .IBL(IBL), .IBH(IBH), .MAR_Load(MAR_Load),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rdy(mem_rdy));

   always #5 clk = ~clk;

   // rdy_at: ACCESS cycle (1-based) in which mem_rdy is high, 0 = never.
   typedef struct {
      bit          is_du;
      bit          we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          rdy_at;
      logic [7:0]  mdata;
      bit          exp_err;
      logic [7:0]  exp_rdata;
      int          exp_cyc;
   } vec_t;

   vec_t q[$];
   vec_t tbl[7];
   int n_pass = 0, n_tot = 0;
   bit inv_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor + memory model, sampled on the falling edge.
   int acc = 0, rd_cnt = 0, wr_cnt = 0;
   bit wd_bad = 0;
   vec_t e;
   always @(negedge clk) begin
      if (mem_rd && mem_wr) inv_bad = 1;
      if (if_gnt && du_gnt) inv_bad = 1;
      if (if_done && du_done) inv_bad = 1;
      if (if_gnt || du_gnt) begin
         chk("gnt_has_expect", q.size() > 0, 1);
         if (q.size() > 0) begin
            chk("gnt_who", {if_gnt, du_gnt}, {!q[0].is_du, q[0].is_du});
            chk("ibh", IBH, q[0].addr[15:8]);
            chk("ibl", IBL, q[0].addr[7:0]);
            chk("mar_load", MAR_Load, 1);
         end
         rd_cnt = 0; wr_cnt = 0; wd_bad = 0;
      end
      if (mem_rd || mem_wr) begin
         acc++;
         rd_cnt += int'(mem_rd);
         wr_cnt += int'(mem_wr);
         if (MAR_Load || IBH != 0 || IBL != 0) wd_bad = 1;
         if (q.size() > 0 && mem_wr && mem_wdata != q[0].wdata) wd_bad = 1;
         if (mem_rd && mem_wdata != 0) wd_bad = 1;
         mem_rdy = (q.size() > 0) && (q[0].rdy_at != 0) && (acc == q[0].rdy_at);
      end else begin
         acc = 0;
         mem_rdy = 1'b0;
      end
      if (if_done || du_done) begin
         chk("done_has_expect", q.size() > 0, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("done_who", {if_done, du_done}, {!e.is_du, e.is_du});
            chk("err", err, e.exp_err);
            chk("rdata", rdata, e.exp_rdata);
            chk("rd_cycles", rd_cnt, e.we ? 0 : e.exp_cyc);
            chk("wr_cycles", wr_cnt, e.we ? e.exp_cyc : 0);
            chk("access_outputs_ok", wd_bad, 0);
            chk("done_mem_idle", {mem_rd, mem_wr, mem_wdata}, 0);
         end
      end
      mem_rdata = (q.size() > 0) ? q[0].mdata : 8'h00;
   end

   task automatic raise(input vec_t v);
      if (v.is_du) begin
         du_req = 1; du_we = v.we; du_addr = v.addr; du_wdata = v.wdata;
      end else begin
         if_req = 1; if_addr = v.addr;
      end
   endtask

   task automatic run_txn(input vec_t v);
      int n;
      @(negedge clk);
      q.push_back(v);
      raise(v);
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(v.is_du ? du_done : if_done) && n < 100);
      chk("done_seen", n < 100, 1);
      chk("latency", n, v.exp_cyc + 2);
      if (v.is_du) du_req = 0; else if_req = 0;
   endtask

   // a is expected to win the tie, b follows after one IDLE cycle.
   task automatic run_tie(input vec_t a, input vec_t b);
      int n;
      @(negedge clk);
      q.push_back(a); q.push_back(b);
      raise(a); raise(b);
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(if_done || du_done) && n < 100);
      chk("tie_first_done", n < 100, 1);
      chk("tie_first_who", du_done, a.is_du);
      if (a.is_du) du_req = 0; else if_req = 0;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(if_gnt || du_gnt) && n < 20);
      chk("tie_gap", n, 2);
      n = 0;
      while (!(b.is_du ? du_done : if_done) && n < 100) begin @(negedge clk); n++; end
      chk("tie_second_done", n < 100, 1);
      if (b.is_du) du_req = 0; else if_req = 0;
   endtask

   vec_t t1, t2, rv;
   int n;

   initial begin
      // is_du we addr wdata rdy_at mdata | err rdata cyc
      tbl[0] = '{0, 0, 16'h1234, 8'h00, 1,  8'hA5, 0, 8'hA5, 1};
      tbl[1] = '{1, 1, 16'h8001, 8'h3C, 3,  8'hEE, 0, 8'hA5, 3};
      tbl[2] = '{1, 0, 16'h4002, 8'h00, 0,  8'h11, 1, 8'hA5, 15};
      tbl[3] = '{1, 0, 16'h4003, 8'h00, 15, 8'h5A, 0, 8'h5A, 15};
      tbl[4] = '{0, 0, 16'hFFFF, 8'h00, 16, 8'h22, 1, 8'h5A, 15};
      tbl[5] = '{1, 0, 16'h00FE, 8'h00, 2,  8'hC3, 0, 8'hC3, 2};
      tbl[6] = '{0, 0, 16'h0100, 8'h00, 1,  8'h77, 0, 8'h77, 1};

      // Reset state.
      #12;
      chk("reset_outputs", {if_gnt, du_gnt, if_done, du_done, err, rdata, IBL, IBH,
                            MAR_Load, mem_rd, mem_wr, mem_wdata}, 0);
      @(negedge clk); rst_n = 1;

      // Tie after reset: fetch first, then data unit.
      t1 = '{0, 0, 16'hAB00, 8'h00, 1, 8'h01, 0, 8'h01, 1};
      t2 = '{1, 0, 16'hCD00, 8'h00, 2, 8'h02, 0, 8'h02, 2};
      run_tie(t1, t2);

      foreach (tbl[i]) run_txn(tbl[i]);

      // Last grant was fetch (tbl[6]): the next tie goes to the data unit.
      t1 = '{1, 1, 16'h5555, 8'h66, 1, 8'h00, 0, 8'h77, 1};
      t2 = '{0, 0, 16'hAAAA, 8'h00, 1, 8'h88, 0, 8'h88, 1};
      run_tie(t1, t2);

      // Reset during the second ACCESS cycle of a fetch.
      rv = '{0, 0, 16'h2468, 8'h00, 3, 8'h44, 0, 8'h44, 3};
      @(negedge clk);
      q.push_back(rv);
      raise(rv);
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_rd && n < 20);
      chk("abort_access_start", mem_rd, 1);
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      chk("abort_outputs", {if_gnt, du_gnt, if_done, du_done, err, rdata, IBL, IBH,
                            MAR_Load, mem_rd, mem_wr, mem_wdata}, 0);
      q.delete();
      rv = '{0, 0, 16'h2468, 8'h00, 1, 8'h99, 0, 8'h99, 1};
      q.push_back(rv);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!if_done && n < 100);
      chk("resume_done", n < 100, 1);
      if_req = 0;
      @(negedge clk); @(negedge clk);
      chk("queue_empty", q.size(), 0);
      chk("invariants", inv_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/epmp_mem_seq.md
EPMP_MEM_SEQ -- requirements
Module: epmp_mem_seq

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, the maximum number of ACCESS cycles spent waiting for mem_rdy (legal range 1..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  the single system clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_req  in  1  fetch-unit access request, level.
- if_addr  in  16  fetch address.
- du_req  in  1  data-unit access request, level.
- du_we  in  1  data-unit write (1) or read (0).
- du_addr  in  16  data-unit address.
- du_wdata  in  8  data-unit write data.
- if_gnt, du_gnt  out  1 each  one-cycle grant pulse to the winning requester.
- if_done, du_done  out  1 each  one-cycle completion pulse to the granted requester.
- err  out  1  timeout flag; valid with the done pulse.
- rdata  out  8  read data; valid with the done pulse and held until the next read completes.
- IBL, IBH  out  8 each  address low and high bytes driven to the MAR input buses.
- MAR_Load  out  1  MAR load strobe.
- mem_rd, mem_wr  out  1 each  memory read and write strobes.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data.
- mem_rdy  in  1  memory ready; sampled only in ACCESS.

Function
REQ-003 The block SHALL implement four states: IDLE, LOAD, ACCESS, DONE. All outputs SHALL be registered or decoded only from state and registered data.
REQ-004 IDLE:
- Requests SHALL be sampled on each rising edge.
- If any request is high, the next state SHALL be LOAD.
- The winner's address, we flag and wdata SHALL be latched. A fetch is always a read.
REQ-005 Arbitration:
- A single request SHALL win.
- If both requests are high, the requester not granted last SHALL win (round-robin).
- The last-grant register SHALL update on entry to LOAD.
REQ-006 LOAD (exactly 1 cycle):
- MAR_Load = 1.
- IBH = latched address[15:8], IBL = latched address[7:0].
- The winner's gnt = 1.
- The next state SHALL be ACCESS unconditionally.
REQ-007 Outside LOAD: MAR_Load, IBL, IBH and both gnt outputs SHALL be 0.
REQ-008 ACCESS (the MAR holds the address from its first cycle):
- mem_rd = 1 for a read, or mem_wr = 1 for a write.
- mem_wdata = latched wdata for a write, 0 otherwise.
- A wait counter SHALL clear on entry to ACCESS and increment on every ACCESS cycle.
REQ-009 On an ACCESS edge with mem_rdy = 1:
- Next state SHALL be DONE with err = 0.
- For a read, rdata SHALL capture mem_rdata on that edge.
REQ-010 If mem_rdy stays 0 for TIMEOUT ACCESS cycles:
- Next state SHALL be DONE with err = 1.
- rdata SHALL be unchanged.
- mem_rdy arriving on the same edge as the timeout SHALL take precedence (err = 0).
REQ-011 DONE (exactly 1 cycle):
- The granted requester's done = 1.
- err SHALL be driven as set in REQ-009/REQ-010.
- mem_rd, mem_wr and mem_wdata SHALL be 0.
- Requests SHALL NOT be sampled.
- The next state SHALL be IDLE.
REQ-012 Requester protocol: a requester SHALL hold req and its address/data stable until it sees done, then drop req on the following edge. The block SHALL NOT support request withdrawal before done.
REQ-013 Latency:
- Request sampled at edge k -> LOAD in cycle k+1 -> ACCESS from cycle k+2.
- Minimum request-to-done is 3 cycles.
- Back-to-back throughput is 1 access per 4 cycles minimum (IDLE, LOAD, ACCESS, DONE).
REQ-014 mem_rd and mem_wr SHALL never be high together. At most one gnt and at most one done SHALL be high in any cycle.

Reset
REQ-015 While rst_n = 0, the following SHALL hold immediately, independent of clk:
- state = IDLE.
- All outputs = 0, including rdata and err.
- Wait counter = 0.
- Last-grant = data unit, so the fetch unit wins the first tie.
REQ-016 Reset asserted mid-access SHALL abort the access without a done pulse. Operation SHALL resume from IDLE on the first clk edge after rst_n rises.

Verification
REQ-017 Fetch read: if_req = 1, if_addr = 16'h1234, mem_rdy = 1 on the first ACCESS cycle, mem_rdata = 8'hA5 -> if_gnt with IBH = 8'h12, IBL = 8'h34, MAR_Load = 1 in cycle 1; mem_rd in cycle 2; if_done = 1, rdata = 8'hA5, err = 0 in cycle 3.
REQ-018 Data write with waits: du_req = 1, du_we = 1, du_addr = 16'h8001, du_wdata = 8'h3C, mem_rdy rising after 3 ACCESS cycles -> mem_wr = 1 and mem_wdata = 8'h3C for 3 cycles; du_done next cycle; mem_rd never high.
REQ-019 Tie after reset: if_req and du_req both 1 -> fetch served first, then the data unit without any idle gap beyond the IDLE cycle. A second simultaneous tie -> data unit wins.
REQ-020 Timeout: du read with mem_rdy = 0 always, TIMEOUT = 15 -> exactly 15 mem_rd cycles, then du_done = 1 and err = 1, with rdata unchanged from its prior value.
REQ-021 Reset mid-ACCESS: rst_n = 0 during the second ACCESS cycle -> all outputs 0 immediately, no done pulse; after release, a pending if_req is serviced normally.
REQ-022 Rdy at timeout: mem_rdy = 1 on the 15th ACCESS edge -> done with err = 0 and rdata = mem_rdata.
